// File: rtl/instruction_fetch_pkg.sv
// Shared front-end constants.
// Imported by fetch, decode and execute.
`ifndef XLEN
`define XLEN 32
`endif

package instruction_fetch_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam int unsigned PC_STRIDE = 4;

endpackage

// File: rtl/fetch_fifo.sv
// In-order response buffer for the fetch stage.
// Flush beats push; push and pop may share a cycle.
module fetch_fifo #(
  parameter  int W     = 64,
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [W-1:0]  data_i,
  input  logic          pop_i,
  input  logic          flush_i,
  output logic [W-1:0]  data_o,
  output logic [CW-1:0] count_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push;
  logic          do_pop;

  assign do_pop  = pop_i && (cnt_q != '0);
  assign do_push = push_i &&
                   ((cnt_q != CW'(DEPTH)) || do_pop);

  // Pointer and occupancy next-state.
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push)
        wr_d = (wr_q == LAST) ? '0 : wr_q + PW'(1);
      if (do_pop)
        rd_d = (rd_q == LAST) ? '0 : rd_q + PW'(1);
      cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Entry storage; validity is tracked by the count.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i)
      mem_q[wr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/instruction_fetch.sv
// Sequential instruction fetch with response buffer.
// Redirect flushes wrong-path work; bubbles are NOPs.
`ifndef XLEN
`define XLEN 32
`endif

module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int              XLEN     = `XLEN,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            halt,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] instruction_out,
  output logic            valid_out
);

  localparam int CW  = $clog2(DEPTH + 1);
  localparam int CW1 = CW + 1;
  localparam logic [XLEN-1:0] NOP    = XLEN'(NOP_INSTR);
  localparam logic [XLEN-1:0] STRIDE = XLEN'(PC_STRIDE);
  localparam logic [XLEN-1:0] ALIGN  = ~XLEN'(3);

  logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0]   rsp_pc_q, rsp_pc_d;
  logic [XLEN-1:0]   pc_out_q, pc_out_d;
  logic [XLEN-1:0]   instr_q, instr_d;
  logic              valid_q, valid_d;
  logic [CW-1:0]     outst_q, outst_d;
  logic [CW-1:0]     drop_q, drop_d;
  logic [CW-1:0]     fifo_cnt;
  logic [2*XLEN-1:0] fifo_head;
  logic              credit;
  logic              fire;
  logic              keep;
  logic              pop;

  assign credit = ({1'b0, outst_q} + {1'b0, fifo_cnt})
                  < CW1'(DEPTH);

  assign imem_req_valid = !rst && !redirect_valid && credit;
  assign imem_req_addr  = fetch_pc_q;
  assign fire = imem_req_valid && imem_req_ready;

  assign keep = imem_rsp_valid && !redirect_valid &&
                (drop_q == '0);
  assign pop  = !halt && !redirect_valid &&
                (fifo_cnt != '0);

  fetch_fifo #(
    .W     (2 * XLEN),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (keep),
    .data_i  ({rsp_pc_q, imem_rsp_data}),
    .pop_i   (pop),
    .flush_i (redirect_valid),
    .data_o  (fifo_head),
    .count_o (fifo_cnt)
  );

  // PC, credit, drop and output-register next-state.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    pc_out_d   = pc_out_q;
    instr_d    = instr_q;
    valid_d    = valid_q;
    drop_d     = drop_q;
    outst_d    = outst_q + CW'(fire)
                 - CW'(imem_rsp_valid);
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc & ALIGN;
      rsp_pc_d   = redirect_pc & ALIGN;
      // The in-flight count already covers every
      // unreturned request, including ones owed a drop.
      drop_d     = outst_q - CW'(imem_rsp_valid);
      instr_d    = NOP;
      valid_d    = 1'b0;
    end else begin
      if (fire)
        fetch_pc_d = fetch_pc_q + STRIDE;
      if (imem_rsp_valid) begin
        if (drop_q != '0)
          drop_d = drop_q - CW'(1);
        else
          rsp_pc_d = rsp_pc_q + STRIDE;
      end
      if (!halt) begin
        if (pop) begin
          pc_out_d = fifo_head[2*XLEN-1:XLEN];
          instr_d  = fifo_head[XLEN-1:0];
          valid_d  = 1'b1;
        end else begin
          instr_d  = NOP;
          valid_d  = 1'b0;
        end
      end
    end
  end

  // Stage state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      pc_out_q   <= RESET_PC;
      instr_q    <= NOP;
      valid_q    <= 1'b0;
      outst_q    <= '0;
      drop_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      pc_out_q   <= pc_out_d;
      instr_q    <= instr_d;
      valid_q    <= valid_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
    end
  end

  assign pc_out          = pc_out_q;
  assign instruction_out = instr_q;
  assign valid_out       = valid_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch.
// Random memory/halt/redirect against a PC-stream model.
module tb_instruction_fetch;
  import instruction_fetch_pkg::*;

  localparam int DEPTH = 4;
  localparam logic [31:0] RPC = 32'h0000_0000;
  localparam logic [31:0] NOP = NOP_INSTR;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        halt = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic [31:0] pc_out;
  logic [31:0] instruction_out;
  logic        valid_out;

  always #5 clk = ~clk;

  instruction_fetch #(
    .XLEN     (32),
    .RESET_PC (RPC),
    .DEPTH    (DEPTH)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .halt            (halt),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_rsp_valid  (imem_rsp_valid),
    .imem_rsp_data   (imem_rsp_data),
    .pc_out          (pc_out),
    .instruction_out (instruction_out),
    .valid_out       (valid_out)
  );

  int total = 0;
  int bad   = 0;

  // expected architectural PC stream, in order
  logic [31:0] exp_q[$];
  // accepted request addresses awaiting a response
  logic [31:0] mem_q[$];

  int ready_pct = 100;
  int rsp_pct   = 100;
  int halt_pct  = 0;
  int redir_pct = 0;
  bit force_redir = 0;
  logic [31:0] force_pc = '0;
  int probe = 0;
  logic [31:0] probe_pc = '0;
  bit fire_seen = 0;
  logic [31:0] fire_addr = '0;
  int valid_cnt = 0;

  function automatic logic [31:0] mem_word(
    input logic [31:0] a);
    return a ^ 32'hA5A5_0100;
  endfunction

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic restart(input logic [31:0] pc);
    exp_q.delete();
    for (int i = 0; i < 1024; i++)
      exp_q.push_back(pc + 32'(4 * i));
  endtask

  task automatic do_redirect(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    restart(pc & ~32'd3);
  endtask

  // observe the handshake that the next edge will take
  task automatic sample();
    if (probe == 1) begin
      check("redir_no_req", 32'(imem_req_valid), 0);
      probe = 2;
    end else if (probe == 2) begin
      check("redir_addr", imem_req_addr, probe_pc);
      probe = 0;
    end
    fire_seen = imem_req_valid && imem_req_ready;
    fire_addr = imem_req_addr;
    if (fire_seen)
      check("credit",
            32'(mem_q.size() + 32'(imem_rsp_valid) + 1
                <= DEPTH), 1);
  endtask

  // memory model plus random control inputs
  task automatic drive();
    if (fire_seen) mem_q.push_back(fire_addr);
    imem_rsp_valid = 1'b0;
    if (mem_q.size() > 0 &&
        $urandom_range(99) < rsp_pct) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(mem_q.pop_front());
    end
    imem_req_ready = ($urandom_range(99) < ready_pct);
    halt = ($urandom_range(99) < halt_pct);
    redirect_valid = 1'b0;
    if (force_redir) begin
      force_redir = 0;
      do_redirect(force_pc);
      probe    = 1;
      probe_pc = force_pc & ~32'd3;
    end else if ($urandom_range(99) < redir_pct) begin
      do_redirect($urandom());
    end
  endtask

  task automatic step();
    @(negedge clk);
    sample();
    @(posedge clk);
    #2;
    drive();
  endtask

  task automatic set_knobs(input int rd, input int rs,
                           input int ht, input int rr);
    ready_pct = rd;
    rsp_pct   = rs;
    halt_pct  = ht;
    redir_pct = rr;
  endtask

  // monitor: compare outputs after every rising edge
  logic        mh, mr;
  logic [31:0] e;
  logic [31:0] last_pc  = RPC;
  logic [31:0] last_ins = NOP;
  logic        last_v   = 1'b0;

  initial begin : monitor
    forever begin
      @(posedge clk);
      mh = halt;
      mr = redirect_valid;
      #1;
      if (rst) begin
        last_pc  = RPC;
        last_ins = NOP;
        last_v   = 1'b0;
        continue;
      end
      if (mr) begin
        check("redir_valid", 32'(valid_out), 0);
        check("redir_nop", instruction_out, NOP);
      end else if (mh) begin
        check("halt_pc", pc_out, last_pc);
        check("halt_ins", instruction_out, last_ins);
        check("halt_v", 32'(valid_out), 32'(last_v));
      end else if (valid_out) begin
        valid_cnt++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL stream: got pc %h want none",
                   pc_out);
        end else begin
          e = exp_q.pop_front();
          check("stream_pc", pc_out, e);
          check("stream_ins", instruction_out,
                mem_word(e));
        end
      end else begin
        check("bubble_nop", instruction_out, NOP);
        check("bubble_pc", pc_out, last_pc);
      end
      last_pc  = pc_out;
      last_ins = instruction_out;
      last_v   = valid_out;
    end
  end

  int vc0;

  initial begin : stim
    set_knobs(100, 100, 0, 0);
    #1 rst = 1'b1;
    #1;
    check("rst_pc", pc_out, RPC);
    check("rst_ins", instruction_out, NOP);
    check("rst_v", 32'(valid_out), 0);
    check("rst_req", 32'(imem_req_valid), 0);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    imem_req_ready = 1'b1;
    restart(RPC);
    @(negedge clk);
    check("first_req_v", 32'(imem_req_valid), 1);
    check("first_req_a", imem_req_addr, RPC);
    sample();
    @(posedge clk);
    #2;
    drive();

    // ideal single-cycle memory stream
    repeat (10) step();
    vc0 = valid_cnt;
    repeat (20) step();
    check("throughput", 32'(valid_cnt - vc0), 20);

    // downstream halt mid-stream
    set_knobs(100, 100, 100, 0);
    repeat (5) step();
    set_knobs(100, 100, 0, 0);
    repeat (8) step();

    // redirect with two requests in flight
    set_knobs(0, 100, 0, 0);
    repeat (6) step();
    set_knobs(100, 0, 0, 0);
    repeat (2) step();
    set_knobs(0, 0, 0, 0);
    force_redir = 1;
    force_pc = 32'h0000_0203;
    step();
    check("in_flight", 32'(mem_q.size()), 2);
    set_knobs(100, 100, 0, 0);
    repeat (12) step();

    // redirect coinciding with a response
    set_knobs(0, 100, 0, 0);
    repeat (6) step();
    set_knobs(100, 0, 0, 0);
    repeat (2) step();
    set_knobs(0, 100, 0, 0);
    force_redir = 1;
    force_pc = 32'h0000_0480;
    step();
    set_knobs(100, 100, 0, 0);
    repeat (12) step();

    // memory not ready for ten cycles
    set_knobs(0, 100, 0, 0);
    repeat (5) step();
    vc0 = valid_cnt;
    repeat (5) step();
    check("stall_idle", 32'(valid_cnt - vc0), 0);
    set_knobs(100, 100, 0, 0);
    repeat (10) step();

    // address wrap
    force_redir = 1;
    force_pc = 32'hFFFF_FFFC;
    vc0 = valid_cnt;
    repeat (12) step();
    check("wrap_seen", 32'(valid_cnt - vc0 >= 3), 1);

    // random traffic
    set_knobs(70, 60, 20, 3);
    repeat (3000) step();
    set_knobs(100, 100, 0, 0);
    repeat (20) step();

    // asynchronous reset mid-stream
    @(posedge clk);
    #4;
    rst = 1'b1;
    #1;
    check("arst_pc", pc_out, RPC);
    check("arst_ins", instruction_out, NOP);
    check("arst_v", 32'(valid_out), 0);
    check("arst_req", 32'(imem_req_valid), 0);
    imem_rsp_valid = 1'b0;
    redirect_valid = 1'b0;
    halt = 1'b0;
    mem_q.delete();
    fire_seen = 0;
    probe = 0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    restart(RPC);
    repeat (20) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
